clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Time-keeping and set-mode controller for the 4-digit HH:MM seven-segment display.
//  Runs a 24 h BCD clock from a 1 s prescaler and sequences a RUN/SET_HOUR/SET_MIN mode FSM from two debounced keys.
//  Produces the per-digit BCD values and a per-digit blank mask consumed by the display driver.
// PARAMETERS
//  TICK_DIV   50_000_000  mclk cycles per second tick (prescaler modulus)
//  BLINK_DIV  12_500_000  mclk cycles per blink-phase toggle (2 Hz blink at 50 MHz)
// PORTS
//  mclk        in   1  system clock
//  rst_n       in   1  asynchronous, active-low reset
//  key_mode    in   1  one-cycle pulse, already debounced/synchronised: advance mode
//  key_inc     in   1  one-cycle pulse, already debounced/synchronised: increment selected field
//  hour_ten    out  3  BCD hours tens, 0..2
//  hour_one    out  4  BCD hours units, 0..9 (0..3 when hour_ten==2)
//  minute_ten  out  3  BCD minutes tens, 0..5
//  minute_one  out  4  BCD minutes units, 0..9
//  blank       out  4  1 = blank digit; [3]=hour_ten [2]=hour_one [1]=minute_ten [0]=minute_one
//  mode        out  2  current FSM state (encoding below)
//  sec_tick    out  1  one-cycle pulse on each counted second (RUN only)
// BEHAVIOUR
//  Reset (async, rst_n low): time 00:00, seconds 0, prescaler 0, blink counter/phase 0, mode RUN, blank 4'b0000, sec_tick 0.
//  All outputs registered; a key pulse in cycle N is reflected on outputs in cycle N+1.
//  FSM: RUN=2'd0, SET_HOUR=2'd1, SET_MIN=2'd2; 2'd3 unreachable, recovers to RUN next cycle.
//   key_mode: RUN->SET_HOUR->SET_MIN->RUN. No other transitions.
//   key_mode and key_inc in the same cycle: mode advances, key_inc discarded.
//  RUN:
//   prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0, sec_tick=1 for that cycle, seconds++.
//   seconds 59->0 carries minute++.
//   minutes: units 9->0 with tens++; 59->00 carries hour++.
//   hours: units 9->0 with tens++; 23->00, no further carry.
//   key_inc ignored. blank=4'b0000.
//  SET_HOUR / SET_MIN:
//   prescaler, seconds and sec_tick held at 0 (time frozen).
//   SET_HOUR key_inc: hours+1 mod 24 (23->00, 09->10, 19->20); minutes untouched, no carry.
//   SET_MIN key_inc: minutes+1 mod 60 (59->00, 09->10); hours untouched, no carry.
//  Blink:
//   blink counter counts 0..BLINK_DIV-1 in the SET states only; phase toggles at each wrap.
//   SET_HOUR: blank={phase,phase,2'b00}. SET_MIN: blank={2'b00,phase,phase}.
//   Every FSM transition and every accepted key_inc clears the blink counter and sets phase=0, so digits are visible.
//  Leaving SET_MIN->RUN: seconds=0, prescaler=0; first sec_tick comes TICK_DIV cycles later.
//  Entering SET_HOUR from RUN: the partial second in progress is discarded.
//  Reset mid-operation, any state: immediate return to the reset values; pending key pulses are lost.
//  Digit values are never outside the ranges listed under PORTS. No illegal BCD is reachable.
// STRUCTURE
//  clock_ctrl_pkg:
//   mode encodings MODE_RUN/MODE_SET_HOUR/MODE_SET_MIN
//   limits SEC_MAX=59, MIN_TEN_MAX=5, HOUR_TEN_MAX=2, HOUR_ONE_MAX_AT_2=3
//   function bcd_inc_mod returning the next {ten,one} for a given modulus (24 or 60)
//  One sub-module: mod_pulse_counter (params MOD; inputs en, clr; output wrap pulse).
//   Instantiated twice: 1 s prescaler (MOD=TICK_DIV) and blink divider (MOD=BLINK_DIV).
//  Top holds the FSM, seconds counter, BCD time registers and blank/output registers.
// TESTING (TICK_DIV=4, BLINK_DIV=3 for simulation)
//  1. Reset: hold rst_n low, then release -> 00:00, mode=0, blank=0000, sec_tick=0; first sec_tick 4 cycles after release.
//  2. Rollover: set time to 23:59, return to RUN, apply 60 ticks -> time 00:00 on the cycle after the 60th sec_tick.
//  3. Set hour: key_mode once (mode=1), then 25 key_inc pulses -> 01:MM, minutes unchanged; key_inc in RUN leaves time unchanged.
//  4. Simultaneous keys: in SET_HOUR, key_mode+key_inc in the same cycle -> mode=2, hours unchanged.
//  5. Blink: in SET_MIN, blank[1:0] toggles 11/00 every 3 cycles while blank[3:2]=00; a key_inc forces blank=0000 next cycle.
//  6. Async reset: rst_n low mid-SET_MIN at 12:34, between clock edges -> outputs 00:00, mode=0, blank=0000 without waiting for mclk.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings, time limits and the BCD increment helper for the
// HH:MM clock/set controller.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2,
      MODE_ILLEGAL  = 2'd3
   } mode_e;

   localparam int unsigned SEC_MAX           = 59;
   localparam int unsigned MIN_TEN_MAX       = 5;
   localparam int unsigned HOUR_TEN_MAX      = 2;
   localparam int unsigned HOUR_ONE_MAX_AT_2 = 3;

   localparam int unsigned MOD_HOUR = 24;
   localparam int unsigned MOD_MIN  = 60;

   // Next {ten,one} of a two-digit BCD value counting modulo 'modulus'
   // (24 or 60); the last legal value wraps to 00.
   function automatic logic [6:0] bcd_inc_mod(input logic [2:0]  ten,
                                              input logic [3:0]  one,
                                              input int unsigned modulus);
      logic [2:0] last_ten;
      logic [3:0] last_one;
      logic [6:0] res;
      last_ten = 3'((modulus - 1) / 10);
      last_one = 4'((modulus - 1) % 10);
      if ((ten == last_ten) && (one == last_one)) begin
         res = '0;
      end else if (one == 4'd9) begin
         res = {ten + 3'd1, 4'd0};
      end else begin
         res = {ten, one + 4'd1};
      end
      return res;
   endfunction

endpackage

// File: rtl/mod_pulse_counter.sv
// Modulo-MOD counter producing a one-cycle wrap pulse; used as the 1 s
// prescaler and as the blink-phase divider.
module mod_pulse_counter #(
   parameter int unsigned MOD = 4
) (
   input  logic mclk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_wrap
);

   localparam int unsigned W    = (MOD > 1) ? $clog2(MOD) : 1;
   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] r_cnt;

   // Wrap is combinational so the owner can register its effect on the same edge.
   assign o_wrap = i_en && !i_clr && (r_cnt == LAST);

   // Count 0..MOD-1 while enabled; clear has priority.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// 24 h BCD clock with RUN / SET_HOUR / SET_MIN mode sequencing and digit
// blanking for the 4-digit HH:MM display.
//
//  state         | meaning
//  MODE_RUN      | time advances from the 1 s prescaler, no blanking
//  MODE_SET_HOUR | time frozen, key_inc bumps hours, hour digits blink
//  MODE_SET_MIN  | time frozen, key_inc bumps minutes, minute digits blink
//  MODE_ILLEGAL  | unreachable, returns to RUN on the next cycle
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned BLINK_DIV = 12_500_000
) (
   input  logic       mclk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       key_inc,
   output logic [2:0] hour_ten,
   output logic [3:0] hour_one,
   output logic [2:0] minute_ten,
   output logic [3:0] minute_one,
   output logic [3:0] blank,
   output logic [1:0] mode,
   output logic       sec_tick
);

   mode_e      r_mode;
   mode_e      w_mode_nxt;
   logic       w_run;
   logic       w_set_hour;
   logic       w_set_min;
   logic       w_set;
   logic       w_mode_evt;
   logic       w_inc_hour;
   logic       w_inc_min;

   logic       w_pre_en;
   logic       w_pre_clr;
   logic       w_sec_wrap;
   logic       w_blink_en;
   logic       w_blink_clr;
   logic       w_blink_wrap;

   logic       r_phase;
   logic       w_phase_nxt;
   logic [3:0] r_blank;
   logic [3:0] w_blank_nxt;
   logic       r_sec_tick;
   logic [5:0] r_sec;

   logic [2:0] r_hour_ten;
   logic [3:0] r_hour_one;
   logic [2:0] r_min_ten;
   logic [3:0] r_min_one;
   logic [6:0] w_hour_inc;
   logic [6:0] w_min_inc;
   logic       w_min_at_max;
   logic       w_min_carry;
   logic       w_hour_carry;

   // Mode state register.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= MODE_RUN;
      end else begin
         r_mode <= w_mode_nxt;
      end
   end

   // Next mode: key_mode cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
   always_comb begin
      w_mode_nxt = r_mode;
      case (r_mode)
         MODE_RUN:      if (key_mode) w_mode_nxt = MODE_SET_HOUR;
         MODE_SET_HOUR: if (key_mode) w_mode_nxt = MODE_SET_MIN;
         MODE_SET_MIN:  if (key_mode) w_mode_nxt = MODE_RUN;
         default:       w_mode_nxt = MODE_RUN;
      endcase
   end

   // Mode decode and key qualification; key_mode wins over key_inc.
   always_comb begin
      w_run      = (r_mode == MODE_RUN);
      w_set_hour = (r_mode == MODE_SET_HOUR);
      w_set_min  = (r_mode == MODE_SET_MIN);
      w_set      = w_set_hour || w_set_min;
      w_mode_evt = (w_mode_nxt != r_mode);
      w_inc_hour = w_set_hour && key_inc && !key_mode;
      w_inc_min  = w_set_min  && key_inc && !key_mode;
   end

   // Leaving RUN discards the partial second; outside RUN the prescaler sits at 0.
   assign w_pre_en    = w_run && !key_mode;
   assign w_pre_clr   = !w_pre_en;
   assign w_blink_clr = !w_set || w_mode_evt || w_inc_hour || w_inc_min;
   assign w_blink_en  = w_set && !w_blink_clr;

   mod_pulse_counter #(.MOD(TICK_DIV)) u_prescaler (
      .mclk   (mclk),
      .rst_n  (rst_n),
      .i_en   (w_pre_en),
      .i_clr  (w_pre_clr),
      .o_wrap (w_sec_wrap)
   );

   mod_pulse_counter #(.MOD(BLINK_DIV)) u_blink_div (
      .mclk   (mclk),
      .rst_n  (rst_n),
      .i_en   (w_blink_en),
      .i_clr  (w_blink_clr),
      .o_wrap (w_blink_wrap)
   );

   // Next blink phase and the blank mask it implies for the next mode.
   always_comb begin
      w_phase_nxt = r_phase;
      if (w_blink_clr) begin
         w_phase_nxt = 1'b0;
      end else if (w_blink_wrap) begin
         w_phase_nxt = !r_phase;
      end
      w_blank_nxt = 4'b0000;
      case (w_mode_nxt)
         MODE_SET_HOUR: w_blank_nxt = {w_phase_nxt, w_phase_nxt, 2'b00};
         MODE_SET_MIN:  w_blank_nxt = {2'b00, w_phase_nxt, w_phase_nxt};
         default:       w_blank_nxt = 4'b0000;
      endcase
   end

   // Blink phase and registered blank mask.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= 1'b0;
         r_blank <= 4'b0000;
      end else begin
         r_phase <= w_phase_nxt;
         r_blank <= w_blank_nxt;
      end
   end

   assign w_min_at_max = (r_min_ten == 3'(MIN_TEN_MAX)) && (r_min_one == 4'd9);
   assign w_min_carry  = w_sec_wrap && (r_sec == 6'(SEC_MAX));
   assign w_hour_carry = w_min_carry && w_min_at_max;
   assign w_min_inc    = bcd_inc_mod(r_min_ten, r_min_one, MOD_MIN);
   assign w_hour_inc   = bcd_inc_mod(r_hour_ten, r_hour_one, MOD_HOUR);

   // Seconds counter and tick pulse; both held at 0 outside RUN.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         r_sec      <= '0;
         r_sec_tick <= 1'b0;
      end else begin
         r_sec_tick <= w_sec_wrap;
         if (!w_pre_en) begin
            r_sec <= '0;
         end else if (w_sec_wrap) begin
            r_sec <= (r_sec == 6'(SEC_MAX)) ? 6'd0 : r_sec + 6'd1;
         end
      end
   end

   // BCD time registers: carries in RUN, direct increments in the SET states.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         r_hour_ten <= '0;
         r_hour_one <= '0;
         r_min_ten  <= '0;
         r_min_one  <= '0;
      end else begin
         if (w_min_carry || w_inc_min) begin
            {r_min_ten, r_min_one} <= w_min_inc;
         end
         if (w_hour_carry || w_inc_hour) begin
            {r_hour_ten, r_hour_one} <= w_hour_inc;
         end
      end
   end

   assign hour_ten   = r_hour_ten;
   assign hour_one   = r_hour_one;
   assign minute_ten = r_min_ten;
   assign minute_one = r_min_one;
   assign blank      = r_blank;
   assign mode       = r_mode;
   assign sec_tick   = r_sec_tick;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl with short dividers.
module tb_clock_set_ctrl;

   logic       mclk;
   logic       rst_n;
   logic       key_mode;
   logic       key_inc;
   logic [2:0] hour_ten;
   logic [3:0] hour_one;
   logic [2:0] minute_ten;
   logic [3:0] minute_one;
   logic [3:0] blank;
   logic [1:0] mode;
   logic       sec_tick;
   logic [15:0] w_time;

   int n_pass  = 0;
   int n_total = 0;

   clock_set_ctrl #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
      .mclk       (mclk),
      .rst_n      (rst_n),
      .key_mode   (key_mode),
      .key_inc    (key_inc),
      .hour_ten   (hour_ten),
      .hour_one   (hour_one),
      .minute_ten (minute_ten),
      .minute_one (minute_one),
      .blank      (blank),
      .mode       (mode),
      .sec_tick   (sec_tick)
   );

   // HHMM readable as hex
   assign w_time = {1'b0, hour_ten, hour_one, 1'b0, minute_ten, minute_one};

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic press(input logic m, input logic i);
      key_mode = m;
      key_inc  = i;
      @(posedge mclk);
      #1;
      key_mode = 1'b0;
      key_inc  = 1'b0;
   endtask

   task automatic test_reset();
      int cyc;
      int first;
      rst_n = 1'b0;
      key_mode = 1'b0;
      key_inc  = 1'b0;
      #2;
      step();
      step();
      n_total++;
      if ({w_time, mode, blank, sec_tick} !== 23'd0)
         $display("FAIL reset_state: time=%h mode=%0d blank=%b tick=%b want 0000/0/0000/0", w_time, mode, blank, sec_tick);
      else n_pass++;
      rst_n = 1'b1;
      first = 0;
      cyc = 0;
      while (first == 0 && cyc < 12) begin
         step();
         cyc++;
         if (sec_tick) first = cyc;
      end
      n_total++;
      if (first !== 4) $display("FAIL first_tick: got cycle %0d want 4", first);
      else n_pass++;
   endtask

   task automatic test_rollover();
      int cyc;
      int ticks;
      int first;
      press(1'b1, 1'b0);
      n_total++;
      if (mode !== 2'd1) $display("FAIL enter_set_hour: mode=%0d want 1", mode);
      else n_pass++;
      repeat (23) press(1'b0, 1'b1);
      n_total++;
      if (w_time !== 16'h2300) $display("FAIL set_23: time=%h want 2300", w_time);
      else n_pass++;
      press(1'b1, 1'b0);
      n_total++;
      if (mode !== 2'd2) $display("FAIL enter_set_min: mode=%0d want 2", mode);
      else n_pass++;
      repeat (59) press(1'b0, 1'b1);
      n_total++;
      if (w_time !== 16'h2359) $display("FAIL set_59: time=%h want 2359", w_time);
      else n_pass++;
      press(1'b0, 1'b1);
      n_total++;
      if (w_time !== 16'h2300) $display("FAIL min_wrap_no_carry: time=%h want 2300", w_time);
      else n_pass++;
      repeat (59) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      n_total++;
      if ({mode, w_time} !== {2'd0, 16'h2359}) $display("FAIL back_to_run: mode=%0d time=%h want 0/2359", mode, w_time);
      else n_pass++;
      cyc = 0;
      ticks = 0;
      first = 0;
      while (ticks < 60 && cyc < 400) begin
         step();
         cyc++;
         if (sec_tick) begin
            ticks++;
            if (ticks == 1) first = cyc;
            if (ticks == 59) begin
               n_total++;
               if (w_time !== 16'h2359) $display("FAIL tick59_time: time=%h want 2359", w_time);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (first !== 4) $display("FAIL tick_after_set: got cycle %0d want 4", first);
      else n_pass++;
      n_total++;
      if (ticks !== 60) $display("FAIL tick_count: got %0d ticks want 60", ticks);
      else n_pass++;
      step();
      n_total++;
      if ({w_time, sec_tick} !== {16'h0000, 1'b0}) $display("FAIL rollover: time=%h tick=%b want 0000/0", w_time, sec_tick);
      else n_pass++;
   endtask

   task automatic test_set_hour();
      int ticks;
      int chk_i [7] = '{9, 10, 19, 20, 23, 24, 25};
      logic [15:0] chk_t [7] = '{16'h0907, 16'h1007, 16'h1907, 16'h2007, 16'h2307, 16'h0007, 16'h0107};
      int k;
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      repeat (7) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      n_total++;
      if ({mode, w_time} !== {2'd1, 16'h0007}) $display("FAIL prep_0007: mode=%0d time=%h want 1/0007", mode, w_time);
      else n_pass++;
      ticks = 0;
      repeat (8) begin
         step();
         if (sec_tick) ticks++;
      end
      n_total++;
      if ({ticks[3:0], w_time} !== {4'd0, 16'h0007}) $display("FAIL frozen: ticks=%0d time=%h want 0/0007", ticks, w_time);
      else n_pass++;
      k = 0;
      for (int i = 1; i <= 25; i++) begin
         press(1'b0, 1'b1);
         if (k < 7 && chk_i[k] == i) begin
            n_total++;
            if (w_time !== chk_t[k]) $display("FAIL hour_inc_%0d: time=%h want %h", i, w_time, chk_t[k]);
            else n_pass++;
            k++;
         end
      end
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      n_total++;
      if ({mode, w_time} !== {2'd0, 16'h0107}) $display("FAIL inc_in_run: mode=%0d time=%h want 0/0107", mode, w_time);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      press(1'b1, 1'b0);
      press(1'b1, 1'b1);
      n_total++;
      if ({mode, w_time, blank} !== {2'd2, 16'h0107, 4'b0000})
         $display("FAIL simultaneous: mode=%0d time=%h blank=%b want 2/0107/0000", mode, w_time, blank);
      else n_pass++;
   endtask

   task automatic test_blink();
      logic [3:0] exp_b [9] = '{4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0011,
                                4'b0000, 4'b0000, 4'b0000, 4'b0011};
      for (int i = 0; i < 9; i++) begin
         step();
         n_total++;
         if (blank !== exp_b[i]) $display("FAIL blink_min_%0d: blank=%b want %b", i + 1, blank, exp_b[i]);
         else n_pass++;
      end
      press(1'b0, 1'b1);
      n_total++;
      if ({blank, w_time} !== {4'b0000, 16'h0108}) $display("FAIL inc_unblank: blank=%b time=%h want 0000/0108", blank, w_time);
      else n_pass++;
      step();
      step();
      n_total++;
      if (blank !== 4'b0000) $display("FAIL blink_hold: blank=%b want 0000", blank);
      else n_pass++;
      step();
      n_total++;
      if (blank !== 4'b0011) $display("FAIL blink_resume: blank=%b want 0011", blank);
      else n_pass++;
      press(1'b1, 1'b0);
      n_total++;
      if ({mode, blank} !== {2'd0, 4'b0000}) $display("FAIL run_unblank: mode=%0d blank=%b want 0/0000", mode, blank);
      else n_pass++;
      press(1'b1, 1'b0);
      repeat (3) step();
      n_total++;
      if (blank !== 4'b1100) $display("FAIL blink_hour: blank=%b want 1100", blank);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      repeat (11) press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      repeat (26) press(1'b0, 1'b1);
      n_total++;
      if ({mode, w_time} !== {2'd2, 16'h1234}) $display("FAIL prep_1234: mode=%0d time=%h want 2/1234", mode, w_time);
      else n_pass++;
      @(posedge mclk);
      #3;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({w_time, mode, blank, sec_tick} !== 23'd0)
         $display("FAIL async_reset: time=%h mode=%0d blank=%b tick=%b want 0000/0/0000/0", w_time, mode, blank, sec_tick);
      else n_pass++;
      step();
      rst_n = 1'b1;
      step();
      n_total++;
      if ({mode, w_time} !== {2'd0, 16'h0000}) $display("FAIL after_release: mode=%0d time=%h want 0/0000", mode, w_time);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_rollover();
      test_set_hour();
      test_simultaneous();
      test_blink();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_total);
      $fatal(1, "timeout");
   end

endmodule
